// File: rtl/decoder3_8.sv
// decoder3_8: registered 3-to-8 one-hot decoder with enable; defining DECODER3_8_COMB_OUT_EN adds the zero-latency y_comb output
module decoder3_8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic       En,
  output logic [7:0] y
`ifdef DECODER3_8_COMB_OUT_EN
  ,
  output logic [7:0] y_comb
`endif
);
  localparam logic [7:0] POL = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;
  logic [7:0] dec, y_d, y_q;
  // one-hot decode of the current select, all lines deasserted when disabled
  always_comb begin
    dec = 8'h00;
    if (En)
      case (sel)
        3'd0: dec = 8'h01;
        3'd1: dec = 8'h02;
        3'd2: dec = 8'h04;
        3'd3: dec = 8'h08;
        3'd4: dec = 8'h10;
        3'd5: dec = 8'h20;
        3'd6: dec = 8'h40;
        3'd7: dec = 8'h80;
        default: dec = 8'h00;
      endcase
  end
  assign y_d = dec ^ POL;
  // register the decode; reset returns every line to its deasserted level
  always_ff @(posedge clk) y_q <= rst ? POL : y_d;
  assign y = y_q;
`ifdef DECODER3_8_COMB_OUT_EN
  assign y_comb = y_d;
`endif
endmodule

// File: tb/tb_decoder3_8.sv
// tb_decoder3_8: scoreboard bench for decoder3_8, checking both output polarities against an arithmetic model
module tb_decoder3_8;
  logic       clk = 1'b0;
  logic       rst, En;
  logic [2:0] sel;
  logic [7:0] y, y_al;
`ifdef DECODER3_8_COMB_OUT_EN
  logic [7:0] y_comb, y_comb_al;
`endif

  typedef struct {logic [7:0] hi; logic [7:0] lo;} exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  decoder3_8 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .sel(sel), .En(En), .y(y)
`ifdef DECODER3_8_COMB_OUT_EN
    , .y_comb(y_comb)
`endif
  );

  decoder3_8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .sel(sel), .En(En), .y(y_al)
`ifdef DECODER3_8_COMB_OUT_EN
    , .y_comb(y_comb_al)
`endif
  );

  // reference: selected line is 2**sel when enabled and not in reset, inverted for active-low
  function automatic logic [7:0] model(bit r, bit e, int s, bit al);
    int v;
    v = (r || !e) ? 0 : 2 ** s;
    return al ? ~8'(v) : 8'(v);
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit e, logic [2:0] s);
    rst = r;
    En  = e;
    sel = s;
`ifdef DECODER3_8_COMB_OUT_EN
    #1;
    chk("y_comb", y_comb, model(0, e, int'(s), 0));
    chk("y_comb_al", y_comb_al, model(0, e, int'(s), 1));
`endif
    @(posedge clk);
    q.push_back('{model(r, e, int'(s), 0), model(r, e, int'(s), 1)});
    #1;
  endtask

  // monitor: every registered result is checked half a cycle after its edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("y", y, e.hi);
      chk("y_al", y_al, e.lo);
      chk("popcount", 8'($countones(y)), (e.hi != 8'h00) ? 8'd1 : 8'd0);
    end
  end

  initial begin
    step(1, 1, 3'd5);
    step(0, 1, 3'd5);
    for (int i = 0; i < 8; i++) step(0, 0, 3'(i));
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i));
    step(0, 1, 3'd3);
    step(0, 0, 3'd3);
    step(0, 1, 3'd3);
    step(0, 1, 3'd7);
    step(1, 1, 3'd7);
    step(0, 1, 3'd7);
    step(0, 1, 3'd2);
    step(0, 1, 3'd6);
    step(1, 0, 3'd0);
    step(0, 1, 3'd0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
